// File: rtl/ram_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_pkg
// Description : Shared defaults and helpers for the synchronous byte-enabled
//               true-dual-port RAM and its arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_dp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_RAM_DEPTH  = 64;
    localparam int DEF_CNT_WIDTH  = 16;

    // Number of byte lanes in a word of the given width
    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage : ram_dp_pkg
`default_nettype wire

// File: rtl/ram_dp_arb.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_arb
// Description : Grant logic for the dual-port RAM. Port 0 always wins; port 1
//               stalls only on a same-address write/write. Stalls are counted
//               in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_arb
    import ram_dp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_0,
    input  logic                  i_we_0,
    input  logic [ADDR_WIDTH-1:0] i_addr_0,
    input  logic                  i_req_1,
    input  logic                  i_we_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    output logic                  o_gnt_0,
    output logic                  o_gnt_1,
    output logic [CNT_WIDTH-1:0]  o_coll_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 w_coll;
    logic [CNT_WIDTH-1:0] r_coll_cnt;

    // Only two writes to the same word collide; reads never conflict
    assign w_coll  = i_req_0 & i_req_1 & i_we_0 & i_we_1 & (i_addr_0 == i_addr_1);
    assign o_gnt_0 = i_req_0;
    assign o_gnt_1 = i_req_1 & ~w_coll;

    // Count port-1 stall cycles, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll_cnt <= '0;
        end else if (w_coll && (r_coll_cnt != c_CNT_MAX)) begin
            r_coll_cnt <= r_coll_cnt + c_CNT_ONE;
        end
    end

    assign o_coll_cnt = r_coll_cnt;

endmodule : ram_dp_arb
`default_nettype wire

// File: rtl/ram_dp_sync_be.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_sync_be
// Description : Parametrised synchronous true-dual-port RAM with byte enables,
//               req/gnt/rvalid handshake per port, read-first semantics,
//               out-of-range error flagging and optional output register.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_sync_be
    import ram_dp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Port 0
    input  logic                    i_req_0,
    input  logic                    i_we_0,
    input  logic [DATA_WIDTH/8-1:0] i_be_0,
    input  logic [ADDR_WIDTH-1:0]   i_addr_0,
    input  logic [DATA_WIDTH-1:0]   i_wdata_0,
    output logic                    o_gnt_0,
    output logic                    o_rvalid_0,
    output logic [DATA_WIDTH-1:0]   o_rdata_0,
    output logic                    o_err_0,
    // Port 1
    input  logic                    i_req_1,
    input  logic                    i_we_1,
    input  logic [DATA_WIDTH/8-1:0] i_be_1,
    input  logic [ADDR_WIDTH-1:0]   i_addr_1,
    input  logic [DATA_WIDTH-1:0]   i_wdata_1,
    output logic                    o_gnt_1,
    output logic                    o_rvalid_1,
    output logic [DATA_WIDTH-1:0]   o_rdata_1,
    output logic                    o_err_1,
    // Collision statistics
    output logic [CNT_WIDTH-1:0]    o_coll_cnt
);

    localparam int LANES = lane_count(DATA_WIDTH);

    // Port signals gathered into arrays so both ports share one description
    logic [1:0]                  w_req;
    logic [1:0]                  w_we;
    logic [1:0]                  w_gnt;
    logic [1:0][LANES-1:0]       w_be;
    logic [1:0][ADDR_WIDTH-1:0]  w_addr;
    logic [1:0][DATA_WIDTH-1:0]  w_wdata;
    logic [1:0]                  w_inr;
    logic [1:0]                  w_rd_acc;
    logic [1:0]                  w_wr_acc;
    logic [1:0]                  w_wr_oor;
    logic [DATA_WIDTH-1:0]       w_rd_data [2];

    logic                        w_rvalid  [2];
    logic                        w_rerr    [2];
    logic                        w_err     [2];
    logic [DATA_WIDTH-1:0]       w_rdata   [2];

    logic [DATA_WIDTH-1:0]       r_mem [RAM_DEPTH];

    assign w_req   = {i_req_1,   i_req_0};
    assign w_we    = {i_we_1,    i_we_0};
    assign w_be    = {i_be_1,    i_be_0};
    assign w_addr  = {i_addr_1,  i_addr_0};
    assign w_wdata = {i_wdata_1, i_wdata_0};

    ram_dp_arb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_0    (w_req[0]),
        .i_we_0     (w_we[0]),
        .i_addr_0   (w_addr[0]),
        .i_req_1    (w_req[1]),
        .i_we_1     (w_we[1]),
        .i_addr_1   (w_addr[1]),
        .o_gnt_0    (w_gnt[0]),
        .o_gnt_1    (w_gnt[1]),
        .o_coll_cnt (o_coll_cnt)
    );

    // Classify each port's access and fetch the pre-write word for reads
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_inr[p]     = (32'(w_addr[p]) < 32'(RAM_DEPTH));
            w_rd_acc[p]  = w_gnt[p] & ~w_we[p];
            w_wr_acc[p]  = w_gnt[p] &  w_we[p];
            w_wr_oor[p]  = w_wr_acc[p] & ~w_inr[p];
            w_rd_data[p] = w_inr[p] ? r_mem[w_addr[p]] : '0;
        end
    end

    // Byte-lane writes from both ports; contents are deliberately not reset.
    // The arbiter guarantees the two ports never write the same word together.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < LANES; b++) begin
                if (w_wr_acc[p] && w_inr[p] && w_be[p][b]) begin
                    r_mem[w_addr[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  r_s1_vld;
        logic                  r_s1_err;
        logic                  r_werr;
        logic [DATA_WIDTH-1:0] r_s1_data;

        // First read stage plus the one-cycle write error pulse; data only
        // moves on a read so the output holds between valid pulses
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_vld  <= 1'b0;
                r_s1_err  <= 1'b0;
                r_werr    <= 1'b0;
                r_s1_data <= '0;
            end else begin
                r_s1_vld <= w_rd_acc[p];
                r_s1_err <= w_rd_acc[p] & ~w_inr[p];
                r_werr   <= w_wr_oor[p];
                if (w_rd_acc[p]) begin
                    r_s1_data <= w_rd_data[p];
                end
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic                  r_out_vld;
            logic                  r_out_err;
            logic [DATA_WIDTH-1:0] r_out_data;

            // Optional second stage, advancing only behind a valid read
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_vld  <= 1'b0;
                    r_out_err  <= 1'b0;
                    r_out_data <= '0;
                end else begin
                    r_out_vld <= r_s1_vld;
                    r_out_err <= r_s1_err;
                    if (r_s1_vld) begin
                        r_out_data <= r_s1_data;
                    end
                end
            end

            assign w_rvalid[p] = r_out_vld;
            assign w_rerr[p]   = r_out_err;
            assign w_rdata[p]  = r_out_data;
        end else begin : g_noreg
            assign w_rvalid[p] = r_s1_vld;
            assign w_rerr[p]   = r_s1_err;
            assign w_rdata[p]  = r_s1_data;
        end

        // Read errors ride with rvalid, write errors follow the grant by one cycle
        assign w_err[p] = w_rerr[p] | r_werr;
    end

    assign o_gnt_0    = w_gnt[0];
    assign o_gnt_1    = w_gnt[1];
    assign o_rvalid_0 = w_rvalid[0];
    assign o_rvalid_1 = w_rvalid[1];
    assign o_rdata_0  = w_rdata[0];
    assign o_rdata_1  = w_rdata[1];
    assign o_err_0    = w_err[0];
    assign o_err_1    = w_err[1];

endmodule : ram_dp_sync_be
`default_nettype wire

// File: tb/tb_ram_dp_sync_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dp_sync_be
// Description : Scoreboard bench. Two RAM instances (depth 64 / no output
//               register, depth 48 / output register, small counter) share one
//               stimulus stream; a word-level model predicts every response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dp_sync_be;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [3:0]  be0 = 0, be1 = 0;
    logic [5:0]  a0 = 0, a1 = 0;
    logic [31:0] d0 = 0, d1 = 0;

    logic        gA0, gA1, vA0, vA1, eA0, eA1, gB0, gB1, vB0, vB1, eB0, eB1;
    logic [31:0] rA0, rA1, rB0, rB1;
    logic [15:0] ccA;
    logic [3:0]  ccB;

    ram_dp_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RAM_DEPTH(64), .OUT_REG(0), .CNT_WIDTH(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req_0(req0), .i_we_0(we0), .i_be_0(be0), .i_addr_0(a0), .i_wdata_0(d0),
        .o_gnt_0(gA0), .o_rvalid_0(vA0), .o_rdata_0(rA0), .o_err_0(eA0),
        .i_req_1(req1), .i_we_1(we1), .i_be_1(be1), .i_addr_1(a1), .i_wdata_1(d1),
        .o_gnt_1(gA1), .o_rvalid_1(vA1), .o_rdata_1(rA1), .o_err_1(eA1),
        .o_coll_cnt(ccA));

    ram_dp_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RAM_DEPTH(48), .OUT_REG(1), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req_0(req0), .i_we_0(we0), .i_be_0(be0), .i_addr_0(a0), .i_wdata_0(d0),
        .o_gnt_0(gB0), .o_rvalid_0(vB0), .o_rdata_0(rB0), .o_err_0(eB0),
        .i_req_1(req1), .i_we_1(we1), .i_be_1(be1), .i_addr_1(a1), .i_wdata_1(d1),
        .o_gnt_1(gB1), .o_rvalid_1(vB1), .o_rdata_1(rB1), .o_err_1(eB1),
        .o_coll_cnt(ccB));

    // Monitor view, index = dut*2 + port
    logic        m_rv [4];
    logic        m_er [4];
    logic [31:0] m_rd [4];
    assign m_rv[0] = vA0; assign m_rv[1] = vA1; assign m_rv[2] = vB0; assign m_rv[3] = vB1;
    assign m_er[0] = eA0; assign m_er[1] = eA1; assign m_er[2] = eB0; assign m_er[3] = eB1;
    assign m_rd[0] = rA0; assign m_rd[1] = rA1; assign m_rd[2] = rB0; assign m_rd[3] = rB1;

    // Reference model state
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic [31:0] mm [2][64];
    int          coll_m [2];
    exp_t        rq [4][$];
    bit          werr [4][8192];
    logic [31:0] last_rd [4];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction
    function automatic int cmax_of(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops an expected read whenever rvalid shows, checks error and hold
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            if (m_rv[i]) begin
                if (rq[i].size() == 0) begin
                    chk($sformatf("unexpected_rvalid[%0d]", i), 64'(m_rv[i]), 64'd0);
                end else begin
                    e = rq[i].pop_front();
                    chk($sformatf("rvalid_cycle[%0d]", i), 64'(cyc), 64'(e.due));
                    chk($sformatf("rdata[%0d]", i), 64'(m_rd[i]), 64'(e.data));
                    chk($sformatf("err_rd[%0d]", i), 64'(m_er[i]), 64'(e.err | werr[i][cyc % 8192]));
                    last_rd[i] = e.data;
                end
            end else begin
                if (rq[i].size() > 0 && rq[i][0].due <= cyc) begin
                    chk($sformatf("missing_rvalid[%0d]", i), 64'(m_rv[i]), 64'd1);
                    void'(rq[i].pop_front());
                end
                chk($sformatf("err[%0d]", i), 64'(m_er[i]), 64'(werr[i][cyc % 8192]));
                chk($sformatf("rdata_hold[%0d]", i), 64'(m_rd[i]), 64'(last_rd[i]));
            end
        end
    end

    // One cycle of stimulus; entered and left just after a rising edge
    task automatic step(input bit r0, input bit w0, input logic [3:0] b0, input logic [5:0] x0, input logic [31:0] y0,
                        input bit r1, input bit w1, input logic [3:0] b1, input logic [5:0] x1, input logic [31:0] y1);
        bit          r [2], w [2], g [2], inr;
        logic [3:0]  b [2];
        logic [5:0]  x [2];
        logic [31:0] y [2];
        r[0] = r0; w[0] = w0; b[0] = b0; x[0] = x0; y[0] = y0;
        r[1] = r1; w[1] = w1; b[1] = b1; x[1] = x1; y[1] = y1;
        chk("coll_cnt_a", 64'(ccA), 64'(coll_m[0]));
        chk("coll_cnt_b", 64'(ccB), 64'(coll_m[1]));
        req0 = r0; we0 = w0; be0 = b0; a0 = x0; d0 = y0;
        req1 = r1; we1 = w1; be1 = b1; a1 = x1; d1 = y1;
        #1;
        g[0] = r0;
        g[1] = r1 && !(r0 && w0 && w1 && (x0 == x1));
        chk("gnt0_a", 64'(gA0), 64'(g[0]));
        chk("gnt1_a", 64'(gA1), 64'(g[1]));
        chk("gnt0_b", 64'(gB0), 64'(g[0]));
        chk("gnt1_b", 64'(gB1), 64'(g[1]));
        for (int d = 0; d < 2; d++) begin
            // reads see the word as it was before this cycle's writes
            for (int p = 0; p < 2; p++) begin
                if (g[p] && !w[p]) begin
                    inr = (int'(x[p]) < depth_of(d));
                    rq[d*2+p].push_back('{cyc + lat_of(d), inr ? mm[d][x[p]] : 32'd0, !inr});
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (g[p] && w[p]) begin
                    if (int'(x[p]) < depth_of(d)) begin
                        for (int l = 0; l < 4; l++)
                            if (b[p][l]) mm[d][x[p]][l*8 +: 8] = y[p][l*8 +: 8];
                    end else begin
                        werr[d*2+p][(cyc + 1) % 8192] = 1'b1;
                    end
                end
            end
            if (r1 && !g[1] && coll_m[d] < cmax_of(d)) coll_m[d]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 6'd0, 32'd0, 0, 0, 4'h0, 6'd0, 32'd0);
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit          hold;
        bit          hr1, hw1, rr0, rw0;
        logic [3:0]  hb1, rb0;
        logic [5:0]  ha1, ra0;
        logic [31:0] hd1, rd0;

        for (int i = 0; i < 4; i++) last_rd[i] = 32'd0;
        coll_m[0] = 0; coll_m[1] = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill every word so later reads are fully defined
        for (int k = 0; k < 32; k++)
            step(1, 1, 4'hF, 6'(k), $urandom, 1, 1, 4'hF, 6'(k + 32), $urandom);

        // Full-word write then read from the other port
        step(1, 1, 4'hF, 6'd5, 32'hDEADBEEF, 0, 0, 4'h0, 6'd0, 32'd0);
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 0, 4'h0, 6'd5, 32'd0);
        // Partial byte-enable write
        step(1, 1, 4'hF, 6'd7, 32'h11223344, 0, 0, 4'h0, 6'd0, 32'd0);
        step(1, 1, 4'h3, 6'd7, 32'h0000AAAA, 0, 0, 4'h0, 6'd0, 32'd0);
        step(1, 0, 4'h0, 6'd7, 32'd0, 1, 1, 4'h0, 6'd7, 32'hFFFFFFFF);
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 0, 4'h0, 6'd7, 32'd0);
        // Same-address write collision: port 1 stalls then completes
        step(1, 1, 4'hF, 6'd9, 32'h1, 1, 1, 4'hF, 6'd9, 32'h2);
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 1, 4'hF, 6'd9, 32'h2);
        step(1, 0, 4'h0, 6'd9, 32'd0, 0, 0, 4'h0, 6'd0, 32'd0);
        // Read-first on a same-cycle cross-port write
        step(1, 1, 4'hF, 6'd3, 32'h44, 0, 0, 4'h0, 6'd0, 32'd0);
        step(1, 1, 4'hF, 6'd3, 32'h55, 1, 0, 4'h0, 6'd3, 32'd0);
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 0, 4'h0, 6'd3, 32'd0);
        // Out-of-range (only for the depth-48 instance) read and write
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 0, 4'h0, 6'd50, 32'd0);
        step(1, 1, 4'hF, 6'd50, 32'hCAFEF00D, 0, 0, 4'h0, 6'd0, 32'd0);
        step(1, 0, 4'h0, 6'd2, 32'd0, 1, 0, 4'h0, 6'd50, 32'd0);
        // Back-to-back reads on both ports
        for (int k = 0; k < 6; k++)
            step(1, 0, 4'h0, 6'(k), 32'd0, 1, 0, 4'h0, 6'(60 - k), 32'd0);
        // Drive the small counter into saturation
        for (int k = 0; k < 20; k++)
            step(1, 1, 4'hF, 6'd20, 32'(k), 1, 1, 4'hF, 6'd20, 32'hABCD0000);
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 1, 4'hF, 6'd20, 32'hABCD0000);
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 0, 4'h0, 6'd20, 32'd0);

        // Random traffic; a stalled port-1 request is held until granted
        hold = 0;
        hr1 = 0; hw1 = 0; hb1 = 0; ha1 = 0; hd1 = 0;
        for (int n = 0; n < 1500; n++) begin
            rr0 = 1'($urandom_range(0, 3) != 0);
            rw0 = 1'($urandom_range(0, 1));
            rb0 = 4'($urandom);
            ra0 = 6'($urandom);
            rd0 = $urandom;
            if (!hold) begin
                hr1 = 1'($urandom_range(0, 3) != 0);
                hw1 = 1'($urandom_range(0, 1));
                hb1 = 4'($urandom);
                ha1 = ($urandom_range(0, 2) == 0) ? ra0 : 6'($urandom);
                hd1 = $urandom;
            end
            hold = hr1 && rr0 && rw0 && hw1 && (ra0 == ha1);
            step(rr0, rw0, rb0, ra0, rd0, hr1, hw1, hb1, ha1, hd1);
        end
        idle();

        // Reset right behind a granted read: pending responses vanish
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 0, 4'h0, 6'd5, 32'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            last_rd[i] = 32'd0;
            for (int c = 0; c < 4; c++) werr[i][(cyc + c) % 8192] = 1'b0;
        end
        coll_m[0] = 0; coll_m[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) idle();
        step(0, 0, 4'h0, 6'd0, 32'd0, 1, 0, 4'h0, 6'd9, 32'd0);
        repeat (4) idle();

        for (int i = 0; i < 4; i++)
            chk($sformatf("queue_drained[%0d]", i), 64'(rq[i].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ram_dp_sync_be
`default_nettype wire

// File: doc/ram_dp_sync_be.md
# ram_dp_sync_be

Parametrised, fully synchronous true-dual-port RAM. It succeeds the fixed 32x64 tri-state dual-port RAM used for the controller's instruction and data stores. It adds:
- separate in/out data buses, byte-enabled writes and a request/grant/valid handshake per port;
- deterministic same-address collision arbitration, an optional output register, and a saturating collision counter.

It sits between the RRAM controller sequencer and its instruction/data buffers.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 6, address width
- RAM_DEPTH, 64, number of words; must be at most 2**ADDR_WIDTH
- OUT_REG, 0, 1 adds a read output register stage
- CNT_WIDTH, 16, collision counter width

Ports (p = 0, 1, one set each):
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_p  in  1  port p access request
- we_p  in  1  1 = write, 0 = read
- be_p  in  DATA_WIDTH/8  byte enables (writes only)
- addr_p  in  ADDR_WIDTH  word address
- wdata_p  in  DATA_WIDTH  write data
- gnt_p  out  1  request accepted this cycle (combinational from current inputs)
- rvalid_p  out  1  rdata_p valid, one-cycle pulse per granted read
- rdata_p  out  DATA_WIDTH  read data
- err_p  out  1  pulses with rvalid_p (reads) or one cycle after grant (writes) when the address is at or above RAM_DEPTH
- coll_cnt  out  CNT_WIDTH  saturating count of port-1 stalls

## Operation
Grants:
- A request is accepted on a rising edge where req_p and gnt_p are both 1.
- While gnt_p is 0 the requester holds req/we/be/addr/wdata stable.
- gnt_0 = req_0 always; port 0 never stalls.
- gnt_1 = req_1 AND NOT (req_0 AND we_0 AND we_1 AND addr_0 == addr_1). Only a same-address write-write is a collision. Port 1 stalls for that cycle, coll_cnt increments, and the counter saturates at all-ones.

Writes:
- Each lane i with be_p[i]=1 updates byte i of mem[addr_p]. be_p = 0 is a legal no-op write.
- Writes to different addresses on both ports in the same cycle both complete.

Reads:
- Reads are read-first: a read in the same cycle as a write to the same address, from either port, returns the pre-write data.
- Out of range (addr at or above RAM_DEPTH): the write is dropped; the read returns rdata 0 with err_p=1.

Output:
- rdata_p holds its last value until the next rvalid_p.

Reset:
- rvalid_p, err_p, rdata_p and coll_cnt clear to 0. gnt_p follows the inputs.
- Memory contents are not reset.
- Reset asserted mid-read: the pending rvalid is cancelled and no pulse is produced after release.

## Timing
- Read latency from the accept edge to rvalid_p high: 1 cycle with OUT_REG=0, 2 cycles with OUT_REG=1.
- Each port sustains one access per cycle, with back-to-back reads fully pipelined.
- A write is visible to a read accepted on the next edge, from either port.
- A stalled port-1 write completes on the first edge where the collision is absent. With port 0 writing the same address continuously, port 1 starves; this is documented behaviour, not an error.
- coll_cnt updates on the edge of the stalled cycle.

## Structure
- Shared package ram_dp_pkg holds the default width/depth constants and a function computing the byte-lane count DATA_WIDTH/8.
- One sub-module, ram_dp_arb: combinational grant logic plus the saturating collision counter.
- The memory array, per-port read pipeline, and range check stay in the top module.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to addr 5 with be=0xF, then port 1 reads addr 5 -> rdata_1=0xDEADBEEF; rvalid_1 at +1 cycle (OUT_REG=0) or +2 (OUT_REG=1).
- Port 0 writes be=0x3, data 0x0000AAAA over 0x11223344 at addr 7 -> later read returns 0x1122AAAA.
- Both ports write addr 9 (port 0 0x1, port 1 0x2) in the same cycle -> gnt_1=0 and coll_cnt=1. Next cycle gnt_1=1 with req_0 low -> final mem[9]=0x2.
- Port 0 writes 0x55 to addr 3 while port 1 reads addr 3 in the same cycle (old value 0x44) -> rdata_1=0x44; a read on the next cycle returns 0x55.
- RAM_DEPTH=48: read addr 50 -> rvalid=1, err=1, rdata=0. Write to addr 50 -> err pulse, and mem[50 mod 48] is unchanged.
- Assert rst_n low one cycle after a granted read with OUT_REG=1 -> no rvalid after release, and coll_cnt=0.
